// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared opcodes, FSM encoding and width defaults for the register-file sequencer.
package rf_seq_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int SEL_W_DEF  = 3;
    typedef enum logic [1:0] {OP_MOV = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_LDI = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RDA = 2'b01, S_RDB = 2'b10, S_WR = 2'b11} state_e;
endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu: combinational add/subtract; the extra top bit is carry (add) or borrow (sub).
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W:0]   res
);
    assign res = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: sequences MOV/ADD/SUB/LDI over an external register bank via a shared read mux
// and one-hot load enables, one register read per cycle.
module rf_seq_ctrl
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_code,
    input  logic [SEL_W-1:0]      op_dst,
    input  logic [SEL_W-1:0]      op_srca,
    input  logic [SEL_W-1:0]      op_srcb,
    input  logic [DATA_W-1:0]     op_imm,
    output logic [SEL_W-1:0]      rd_sel,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [(1<<SEL_W)-1:0] wr_load,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  done,
    output logic                  carry
);
    localparam int NREG = 1 << SEL_W;

    state_e            state, nxt;
    op_e               op;
    logic [SEL_W-1:0]  dst, srca, srcb;
    logic [DATA_W-1:0] imm, opa, opb, result;
    logic [DATA_W:0]   alu_res;
    logic              accept;

    assign accept = (state == S_IDLE) && op_valid;

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .a   (opa),
        .b   (opb),
        .sub (op == OP_SUB),
        .res (alu_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op    <= OP_MOV;
            dst   <= '0;
            srca  <= '0;
            srcb  <= '0;
            imm   <= '0;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                op   <= op_e'(op_code);
                dst  <= op_dst;
                srca <= op_srca;
                srcb <= op_srcb;
                imm  <= op_imm;
            end
            if (state == S_RDA) opa <= rd_data;
            if (state == S_RDB) opb <= rd_data;
            if (state == S_WR && (op == OP_ADD || op == OP_SUB)) carry <= alu_res[DATA_W];
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (op_valid) nxt = (op_e'(op_code) == OP_LDI) ? S_WR : S_RDA;
            S_RDA:   nxt = (op == OP_MOV) ? S_WR : S_RDB;
            S_RDB:   nxt = S_WR;
            default: nxt = S_IDLE;
        endcase
    end

    assign result   = (op == OP_MOV) ? opa : (op == OP_LDI) ? imm : alu_res[DATA_W-1:0];
    assign op_ready = (state == S_IDLE);
    assign rd_sel   = (state == S_RDA) ? srca : (state == S_RDB) ? srcb : '0;
    assign done     = (state == S_WR);
    assign wr_data  = done ? result : '0;
    assign wr_load  = done ? ({{(NREG-1){1'b0}}, 1'b1} << dst) : '0;
endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: directed table of operations against a behavioural 8-entry register bank,
// plus hand sequences for read-select order, back-to-back accepts and mid-operation reset.
module tb_rf_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = 2'b00;
    logic [2:0]  op_dst = 3'd0, op_srca = 3'd0, op_srcb = 3'd0;
    logic [15:0] op_imm = 16'h0;
    logic [2:0]  rd_sel;
    logic [15:0] rd_data;
    logic [7:0]  wr_load;
    logic [15:0] wr_data;
    logic        done;
    logic        carry;
    logic [15:0] regs [8];
    int          n_vec = 0;
    int          n_mis = 0;

    localparam logic [1:0] MOV = 2'b00, ADD = 2'b01, SUB = 2'b10, LDI = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  dst, a, b;
        logic [15:0] imm, data;
        logic [7:0]  load;
        logic        cy;
        int          lat;
    } vec_t;
    vec_t tbl [14];

    rf_seq_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_dst(op_dst), .op_srca(op_srca), .op_srcb(op_srcb),
        .op_imm(op_imm), .rd_sel(rd_sel), .rd_data(rd_data), .wr_load(wr_load),
        .wr_data(wr_data), .done(done), .carry(carry)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_sel];
    always @(posedge clk)
        for (int i = 0; i < 8; i++) if (wr_load[i]) regs[i] <= wr_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int lat;
        lat = 0;
        @(negedge clk);
        op_code = v.op; op_dst = v.dst; op_srca = v.a; op_srcb = v.b; op_imm = v.imm;
        op_valid = 1'b1;
        chk($sformatf("v%0d ready", idx), 32'(op_ready), 32'd1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d wr_load", idx), 32'(wr_load), 32'(v.load));
        chk($sformatf("v%0d wr_data", idx), 32'(wr_data), 32'(v.data));
        @(negedge clk);
        chk($sformatf("v%0d carry", idx), 32'(carry), 32'(v.cy));
        chk($sformatf("v%0d done_off", idx), 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_rdy, exp_done;
        tbl[0]  = '{LDI, 3'd3, 3'd0, 3'd0, 16'hA5A5, 16'hA5A5, 8'h08, 1'b0, 1};
        tbl[1]  = '{LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 8'h02, 1'b0, 1};
        tbl[2]  = '{LDI, 3'd2, 3'd0, 3'd0, 16'h0002, 16'h0002, 8'h04, 1'b0, 1};
        tbl[3]  = '{ADD, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0001, 8'h01, 1'b1, 3};
        tbl[4]  = '{LDI, 3'd4, 3'd0, 3'd0, 16'h0005, 16'h0005, 8'h10, 1'b1, 1};
        tbl[5]  = '{LDI, 3'd5, 3'd0, 3'd0, 16'h0007, 16'h0007, 8'h20, 1'b1, 1};
        tbl[6]  = '{SUB, 3'd4, 3'd4, 3'd5, 16'h0000, 16'hFFFE, 8'h10, 1'b1, 3};
        tbl[7]  = '{LDI, 3'd6, 3'd0, 3'd0, 16'h1234, 16'h1234, 8'h40, 1'b1, 1};
        tbl[8]  = '{MOV, 3'd7, 3'd6, 3'd0, 16'h0000, 16'h1234, 8'h80, 1'b1, 2};
        tbl[9]  = '{ADD, 3'd2, 3'd2, 3'd2, 16'h0000, 16'h0004, 8'h04, 1'b0, 3};
        tbl[10] = '{SUB, 3'd1, 3'd1, 3'd0, 16'h0000, 16'hFFFE, 8'h02, 1'b0, 3};
        tbl[11] = '{SUB, 3'd3, 3'd3, 3'd3, 16'h0000, 16'h0000, 8'h08, 1'b0, 3};
        tbl[12] = '{ADD, 3'd5, 3'd1, 3'd1, 16'h0000, 16'hFFFC, 8'h20, 1'b1, 3};
        tbl[13] = '{MOV, 3'd0, 3'd4, 3'd0, 16'h0000, 16'hFFFE, 8'h01, 1'b1, 2};

        repeat (2) @(negedge clk);
        chk("rst ready", 32'(op_ready), 32'd1);
        chk("rst outs", {rd_sel, wr_load, done, carry}, 32'd0);
        chk("rst wr_data", 32'(wr_data), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) run_op(tbl[i], i);
        chk("bank r5", 32'(regs[5]), 32'hFFFC);
        chk("bank r0", 32'(regs[0]), 32'hFFFE);

        // Read-select order for ADD R6 = R6 + R2 (0x1234 + 4)
        @(negedge clk);
        op_code = ADD; op_dst = 3'd6; op_srca = 3'd6; op_srcb = 3'd2; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk("seqA rd_sel a", 32'(rd_sel), 32'd6);
        chk("seqA busy", 32'(op_ready), 32'd0);
        @(negedge clk);
        chk("seqA rd_sel b", 32'(rd_sel), 32'd2);
        @(negedge clk);
        chk("seqA done", {done, wr_load, rd_sel}, {1'b1, 8'h40, 3'd0});
        chk("seqA wr_data", 32'(wr_data), 32'h1238);
        @(negedge clk);
        chk("seqA carry", 32'(carry), 32'd0);

        // Back-to-back ADD R2 = R2 + R2 with op_valid held: 4 -> 8 -> 16
        exp_rdy  = 8'b1000_1000;
        exp_done = 8'b0100_0100;
        op_code = ADD; op_dst = 3'd2; op_srca = 3'd2; op_srcb = 3'd2; op_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 4) op_valid = 1'b0;
            chk($sformatf("seqB ready c%0d", k), 32'(op_ready), 32'(exp_rdy[k]));
            chk($sformatf("seqB done c%0d", k), 32'(done), 32'(exp_done[k]));
            if (k == 2) chk("seqB data1", 32'(wr_data), 32'h0008);
            if (k == 6) chk("seqB data2", 32'(wr_data), 32'h0010);
        end
        chk("seqB bank r2", 32'(regs[2]), 32'h0010);

        // Force carry to 1, then reset during RDB of an ADD R7 = R0 + R1
        run_op('{ADD, 3'd3, 3'd0, 3'd1, 16'h0000, 16'hFFFC, 8'h08, 1'b1, 3}, 14);
        @(negedge clk);
        op_code = ADD; op_dst = 3'd7; op_srca = 3'd0; op_srcb = 3'd1; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("seqC in RDB", 32'(rd_sel), 32'd1);
        reset = 1'b0;
        #1;
        chk("seqC rst outs", {rd_sel, wr_load, done, carry}, 32'd0);
        chk("seqC rst data", 32'(wr_data), 32'd0);
        chk("seqC rst ready", 32'(op_ready), 32'd1);
        @(negedge clk);
        chk("seqC hold load", 32'(wr_load), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("seqC post ready c%0d", k), 32'(op_ready), 32'd1);
            chk($sformatf("seqC post load c%0d", k), 32'(wr_load), 32'd0);
        end
        chk("seqC r7 kept", 32'(regs[7]), 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
